// File: rtl/register_file.sv
// MIPS general-purpose register file: 2**ADDR_WIDTH words, two combinational read
// ports, one synchronous write port, entry 0 hardwired to zero. Optional REGFILE_BYPASS_EN.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic                  wr_en;

    // Writes to index 0 are dropped here, so entry 0 only ever holds its reset value.
    assign wr_en = reg_write && !rst && (write_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[write_reg] <= write_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] idx;
            logic [DATA_WIDTH-1:0] data;

            assign idx = (gi == 0) ? read_reg1 : read_reg2;

            // Index 0 is forced to zero so the port is defined even before the first reset.
            always_comb begin
                data = '0;
                if (!rst && (idx != '0)) begin
                    data = regs_q[idx];
`ifdef REGFILE_BYPASS_EN
                    if (wr_en && (write_reg == idx)) begin
                        data = write_data;
                    end
`endif
                end
            end
        end
    endgenerate

    assign read_data1 = g_rd[0].data;
    assign read_data2 = g_rd[1].data;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: array-based reference model checked every
// cycle, directed literal checks from the test plan, then randomized traffic.
module tb_register_file;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] read_reg1 = '0;
    logic [AW-1:0] read_reg2 = '0;
    logic [AW-1:0] write_reg;
    logic [AW-1:0] wr_idx_drv = '0;
    logic [DW-1:0] write_data = '0;
    logic          reg_write = 1'b0;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;

    // Destination-register select mux: a=31 (rt), b=15 (rd).
    logic use_mux = 1'b0;
    logic mux_sel = 1'b0;
    assign write_reg = use_mux ? (mux_sel ? 5'd15 : 5'd31) : wr_idx_drv;

    int tests  = 0;
    int errors = 0;

    logic [DW-1:0] model [32];

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .write_reg (write_reg),
        .write_data(write_data),
        .reg_write (reg_write),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
    end

    // Reference storage: reset clears everything, otherwise a nonzero-index write lands.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] <= '0;
        end else if (reg_write && write_reg != 0) begin
            model[write_reg] <= write_data;
        end
    end

    function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] idx);
        if (rst || idx == 0) return '0;
        if (BYP && reg_write && write_reg == idx) return write_data;
        return model[idx];
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Model compare on every cycle, sampled mid-cycle once inputs have settled.
    always @(negedge clk) begin
        check("model_port1", read_data1, expect_read(read_reg1));
        check("model_port2", read_data2, expect_read(read_reg2));
    end

    task automatic step(input logic r, input logic we, input logic [AW-1:0] wi,
                        input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(posedge clk);
        #1;
        rst = r; reg_write = we; wr_idx_drv = wi; write_data = wd;
        read_reg1 = r1; read_reg2 = r2;
        @(negedge clk);
        $display("[TB] rst=%0d we=%0d wr=%0d wd=%08h r1=%0d->%08h r2=%0d->%08h",
                 rst, reg_write, write_reg, write_data, read_reg1, read_data1, read_reg2, read_data2);
    endtask

    initial begin
        // Reset clear
        step(1, 0, 0, 0, 7, 7);
        check("reset_out1", read_data1, 32'h0);
        check("reset_out2", read_data2, 32'h0);
        step(0, 1, 7, 32'hDEADBEEF, 7, 0);
        step(1, 0, 0, 0, 7, 7);
        check("rst_cycle1", read_data1, 32'h0);
        check("rst_cycle2", read_data2, 32'h0);
        step(0, 0, 0, 0, 7, 7);
        check("reg7_cleared", read_data1, 32'h0);

        // Basic write/read
        step(0, 1, 31, 32'h12345678, 0, 0);
        step(0, 1, 1, 32'h0000ABCD, 0, 0);
        step(0, 0, 0, 0, 31, 1);
        check("reg31", read_data1, 32'h12345678);
        check("reg1", read_data2, 32'h0000ABCD);

        // $0 immutability
        step(0, 1, 0, 32'hFFFFFFFF, 0, 0);
        check("zero_pre1", read_data1, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        check("zero_post1", read_data1, 32'h0);
        check("zero_post2", read_data2, 32'h0);

        // Write-enable gating
        step(0, 0, 15, 32'hCAFEF00D, 15, 15);
        step(0, 0, 0, 0, 15, 15);
        check("we_gate", read_data1, 32'h0);

        // Same-cycle hazard
        step(0, 1, 15, 32'h11111111, 0, 0);
        step(0, 1, 15, 32'h22222222, 15, 0);
        check("hazard_pre", read_data1, BYP ? 32'h22222222 : 32'h11111111);
        step(0, 0, 0, 0, 15, 0);
        check("hazard_post", read_data1, 32'h22222222);

        // Mux-driven write index
        use_mux = 1'b1;
        mux_sel = 1'b0;
        step(0, 1, 0, 32'hA5A5A5A5, 0, 0);
        @(posedge clk);
        #1 mux_sel = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        use_mux = 1'b0; reg_write = 1'b0; read_reg1 = 31; read_reg2 = 15;
        @(negedge clk);
        check("mux_reg31", read_data1, 32'hA5A5A5A5);
        check("mux_reg15", read_data2, 32'hA5A5A5A5);

        // Randomized traffic, including occasional mid-sequence resets
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
                 AW'($urandom_range(0, 31)), DW'($urandom),
                 AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
        end

        @(posedge clk);
        #1 reg_write = 1'b0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
